// File: rtl/hazard_scoreboard_pkg.sv
// Shared processor definitions: forward-select encodings, PC register index,
// the shadow-stage record and the forwarding priority helper.
package hazard_scoreboard_pkg;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_RESW = 2'b01,
    FWD_ALUM = 2'b10
  } fwd_e;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef struct packed {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    logic       regwrite;
    logic       memtoreg;
    logic       pcsrc;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{
    ra1: 4'd0, ra2: 4'd0, wa3: 4'd0,
    regwrite: 1'b0, memtoreg: 1'b0, pcsrc: 1'b0
  };

  // The PC is never forwarded; the younger producer in M beats the one in W.
  function automatic fwd_e fwd_sel(input shadow_t m, input shadow_t w, input logic [3:0] ra);
    fwd_e sel;
    if (ra == PC_REG) begin
      sel = FWD_RF;
    end else if (m.regwrite && (m.wa3 == ra)) begin
      sel = FWD_ALUM;
    end else if (w.regwrite && (w.wa3 == ra)) begin
      sel = FWD_RESW;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage: loads its input every cycle, or a bubble when flushed.
module hazard_stage_reg
  import hazard_scoreboard_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  input  shadow_t d,
  output shadow_t q
);

  // Stage register with bubble insertion on flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= SHADOW_BUBBLE;
    end else if (flush) begin
      q <= SHADOW_BUBBLE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for a 5-stage pipeline: tracks E/M/W instruction shadows and
// produces forwarding selects, stall/flush controls and a stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  RA1D,
  input  logic [3:0]  RA2D,
  input  logic [3:0]  WA3D,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        PCSrcD,
  input  logic        CondExE,
  input  logic        BranchTakenE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] StallCount
);

  shadow_t     d_s;
  shadow_t     m_next_s;
  shadow_t     e_r;
  shadow_t     m_r;
  shadow_t     w_r;
  logic        ld_stall_s;
  logic        pc_wr_pend_s;
  logic [31:0] stall_count_r;

  assign d_s = '{
    ra1: RA1D, ra2: RA2D, wa3: WA3D,
    regwrite: RegWriteD, memtoreg: MemtoRegD, pcsrc: PCSrcD
  };

  // An instruction whose condition fails in E must not write registers or the PC later
  always_comb begin
    m_next_s          = e_r;
    m_next_s.regwrite = e_r.regwrite & CondExE;
    m_next_s.pcsrc    = e_r.pcsrc & CondExE;
  end

  hazard_stage_reg u_stage_e (
    .clk   (clk),
    .reset (reset),
    .flush (FlushE),
    .d     (d_s),
    .q     (e_r)
  );

  hazard_stage_reg u_stage_m (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .d     (m_next_s),
    .q     (m_r)
  );

  hazard_stage_reg u_stage_w (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .d     (m_r),
    .q     (w_r)
  );

  // Load-use and PC-write hazard detection plus E-stage operand forwarding
  always_comb begin
    ld_stall_s   = e_r.memtoreg & e_r.regwrite &
                   ((e_r.wa3 == RA1D) | (e_r.wa3 == RA2D));
    pc_wr_pend_s = PCSrcD | (e_r.pcsrc & CondExE) | m_r.pcsrc | w_r.pcsrc;
    StallF       = ld_stall_s | pc_wr_pend_s;
    StallD       = ld_stall_s;
    FlushD       = pc_wr_pend_s | BranchTakenE;
    FlushE       = ld_stall_s | BranchTakenE;
    ForwardAE    = fwd_sel(m_r, w_r, e_r.ra1);
    ForwardBE    = fwd_sel(m_r, w_r, e_r.ra2);
  end

  // Saturating count of decode-stall cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_r <= 32'd0;
    end else if (StallD && (stall_count_r != 32'hFFFF_FFFF)) begin
      stall_count_r <= stall_count_r + 32'd1;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign StallCount = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: an in-flight instruction queue model,
// directed pipeline scenarios with literal expectations, then randomized traffic.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  RA1D = 4'd0, RA2D = 4'd0, WA3D = 4'd0;
  logic        RegWriteD = 1'b0, MemtoRegD = 1'b0, PCSrcD = 1'b0;
  logic        CondExE = 1'b1, BranchTakenE = 1'b0;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] StallCount;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
    bit         rw;
    bit         mr;
    bit         pc;
  } ins_t;

  // In-flight instructions, youngest first: [0] in E, [1] in M, [2] in W.
  ins_t        pipe[$];
  int unsigned mcount;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3D         (WA3D),
    .RegWriteD    (RegWriteD),
    .MemtoRegD    (MemtoRegD),
    .PCSrcD       (PCSrcD),
    .CondExE      (CondExE),
    .BranchTakenE (BranchTakenE),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .StallCount   (StallCount)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic ins_t bubble();
    ins_t b;
    b.ra1 = 4'd0; b.ra2 = 4'd0; b.wa3 = 4'd0;
    b.rw = 1'b0; b.mr = 1'b0; b.pc = 1'b0;
    return b;
  endfunction

  function automatic logic [1:0] want_fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (pipe[1].rw && (pipe[1].wa3 == ra)) return 2'b10;
    if (pipe[2].rw && (pipe[2].wa3 == ra)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit want_ld();
    return pipe[0].mr && pipe[0].rw && ((pipe[0].wa3 == RA1D) || (pipe[0].wa3 == RA2D));
  endfunction

  function automatic bit want_pend();
    return PCSrcD || (pipe[0].pc && CondExE) || pipe[1].pc || pipe[2].pc;
  endfunction

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(bubble());
    mcount = 0;
  endtask

  task automatic model_step();
    ins_t leaving;
    ins_t entering;
    bit   ld;
    ld = want_ld();
    if (ld && (mcount != 32'hFFFF_FFFF)) mcount++;
    leaving    = pipe[0];
    leaving.rw = leaving.rw && CondExE;
    leaving.pc = leaving.pc && CondExE;
    pipe[0]    = leaving;
    if (ld || BranchTakenE) begin
      entering = bubble();
    end else begin
      entering.ra1 = RA1D; entering.ra2 = RA2D; entering.wa3 = WA3D;
      entering.rw = RegWriteD; entering.mr = MemtoRegD; entering.pc = PCSrcD;
    end
    pipe.push_front(entering);
    leaving = pipe.pop_back();
  endtask

  // Reference model advances on the same edges as the design
  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("ForwardAE", {30'd0, ForwardAE}, {30'd0, want_fwd(pipe[0].ra1)});
      check("ForwardBE", {30'd0, ForwardBE}, {30'd0, want_fwd(pipe[0].ra2)});
      check("StallF", {31'd0, StallF}, {31'd0, want_ld() || want_pend()});
      check("StallD", {31'd0, StallD}, {31'd0, want_ld()});
      check("FlushD", {31'd0, FlushD}, {31'd0, want_pend() || BranchTakenE});
      check("FlushE", {31'd0, FlushE}, {31'd0, want_ld() || BranchTakenE});
      check("StallCount", StallCount, mcount);
    end
  end

  task automatic setd(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w,
                      input bit rw, input bit mr, input bit pc, input bit cond, input bit br);
    @(posedge clk);
    #1;
    RA1D = a1; RA2D = a2; WA3D = w;
    RegWriteD = rw; MemtoRegD = mr; PCSrcD = pc;
    CondExE = cond; BranchTakenE = br;
  endtask

  task automatic nop();
    setd(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fa"}, {30'd0, ForwardAE}, 32'd0);
    check({tag, "_fb"}, {30'd0, ForwardBE}, 32'd0);
    check({tag, "_ctl"}, {28'd0, StallF, StallD, FlushD, FlushE}, 32'd0);
    check({tag, "_cnt"}, StallCount, 32'd0);
  endtask

  task automatic do_reset();
    nop();
    reset = 1'b1;
    mid();
    check_all_zero("reset");
    reset = 1'b0;
  endtask

  function automatic logic [3:0] rreg();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 4'd15 : k[3:0];
  endfunction

  initial begin
    #2 reset = 1'b1;
    #4 reset = 1'b0;
    chk_en = 1'b1;
    do_reset();

    // ADD R1 then SUB R2,R1,R3: ALU result forwarded from M
    nop(); nop(); nop();
    setd(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    setd(4'd1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    nop(); mid();
    check("adj_fa", {30'd0, ForwardAE}, 32'd2);
    check("adj_fb", {30'd0, ForwardBE}, 32'd0);

    // ADD R1, NOP, SUB R2,R1,R1: result forwarded from W on both operands
    nop(); nop(); nop();
    setd(4'd2, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    nop();
    setd(4'd1, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    nop(); mid();
    check("gap_fa", {30'd0, ForwardAE}, 32'd1);
    check("gap_fb", {30'd0, ForwardBE}, 32'd1);

    // LDR R4 then ADD R5,R4,R6: one stall, then forward from W
    do_reset();
    setd(4'd5, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    setd(4'd4, 4'd6, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mid();
    check("ldu_stall", {29'd0, StallF, StallD, FlushE}, 32'd7);
    check("ldu_cnt0", StallCount, 32'd0);
    setd(4'd4, 4'd6, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mid();
    check("ldu_nostall", {31'd0, StallD}, 32'd0);
    check("ldu_cnt1", StallCount, 32'd1);
    nop(); mid();
    check("ldu_fa", {30'd0, ForwardAE}, 32'd1);

    // MOV PC: four cycles of fetch stall / decode flush, one if predicated off
    nop(); nop(); nop();
    setd(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nop();
      mid();
      check("movpc_sf", {31'd0, StallF}, (i < 4) ? 32'd1 : 32'd0);
      check("movpc_fd", {31'd0, FlushD}, (i < 4) ? 32'd1 : 32'd0);
    end
    setd(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    mid();
    check("movpc_nc0", {30'd0, StallF, FlushD}, 32'd3);
    setd(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mid();
    check("movpc_nc1", {30'd0, StallF, FlushD}, 32'd0);
    nop(); mid();
    check("movpc_nc2", {30'd0, StallF, FlushD}, 32'd0);

    // Taken branch in the same cycle as a load-use hazard
    nop(); nop(); nop();
    setd(4'd5, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    setd(4'd4, 4'd6, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    mid();
    check("brld_flush", {29'd0, FlushD, FlushE, StallD}, 32'd7);
    nop(); mid();
    check("brld_next", {29'd0, StallF, StallD, FlushE}, 32'd0);

    // Reset pulsed in the middle of a load-use stall
    nop(); nop(); nop();
    setd(4'd5, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    setd(4'd4, 4'd6, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    mid();
    check("rst_pre", {31'd0, StallD}, 32'd1);
    reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    #1 reset = 1'b0;
    setd(4'd0, 4'd0, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    setd(4'd15, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    nop(); mid();
    check("pc_nofwd", {30'd0, ForwardAE}, 32'd0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      bit rw;
      rw = ($urandom_range(0, 3) != 0);
      setd(rreg(), rreg(), rreg(), rw, rw && ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 9) == 0));
      reset = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
